rtc_time_ctrl: RTL and testbench
================================

Name: rtc_time_ctrl

Overview:
Timekeeping controller that sits directly downstream of the 1 Hz divider. It consumes the divider's single-cycle one-second pulse and keeps BCD hours:minutes:seconds (24 h). It sequences the divider through `div_rst` so that the sub-second phase restarts on every time set, on every resume from hold, and after reset. It also provides a host set handshake and a sticky alarm interrupt.

Parameters:
DIV_RST_CYCLES, 4, number of clk cycles `div_rst` is held in SYNC; range 1..255.
ALARM_EN_DEFAULT, 0, reset value of the internal alarm-armed flag.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tick_1hz  in  1  single-cycle one-second pulse from divider
div_rst  out  1  divider reset/hold request
hold  in  1  level; freeze timekeeping while high
set_req  in  1  level; request to load set_hour/min/sec
set_hour  in  8  BCD hour 0x00..0x23
set_min  in  8  BCD minute 0x00..0x59
set_sec  in  8  BCD second 0x00..0x59
set_ack  out  1  one-cycle completion pulse
set_err  out  1  one-cycle, coincident with set_ack, when the load was rejected
hour  out  8  current BCD hour
min  out  8  current BCD minute
sec  out  8  current BCD second
sec_pulse  out  1  one-cycle pulse when sec advances
min_pulse  out  1  one-cycle pulse when min advances
hour_pulse  out  1  one-cycle pulse when hour advances
day_pulse  out  1  one-cycle pulse on 23:59:59 -> 00:00:00
alarm_en  in  1  arm/disarm alarm; sampled every cycle
alarm_time  in  24  {hour,min,sec} BCD alarm compare value
alarm_clr  in  1  clear alarm_irq
alarm_irq  out  1  sticky alarm flag

Behaviour:
- Reset values: hour, min, sec = 0x00; all pulses = 0; set_ack, set_err = 0; alarm_irq = 0; div_rst = 1; state = SYNC with the counter loaded to DIV_RST_CYCLES.
- States:
  - RUN: div_rst = 0.
  - SYNC: div_rst = 1 for exactly DIV_RST_CYCLES cycles, then RUN.
  - HALT: div_rst = 1 continuously.
- RUN tick:
  - On the cycle after tick_1hz, sec increments and sec_pulse = 1.
  - Units digit 9 -> 0 carries into the tens digit.
  - sec 0x59 -> 0x00 increments min and pulses min_pulse; min 0x59 -> 0x00 increments hour and pulses hour_pulse.
  - hour 0x23 -> 0x00 pulses day_pulse.
  - All pulses for one tick are coincident and registered; latency from tick is 1 cycle.
- tick_1hz is ignored in SYNC and HALT.
- Set handshake:
  - A request is accepted only when set_req = 1 and the internal `armed` flag = 1. `armed` is cleared on accept and set again when set_req is sampled 0.
  - Invalid request (any units digit > 9, sec/min > 0x59, or hour > 0x23): next cycle set_ack = 1 and set_err = 1, time unchanged, state unchanged.
  - Valid request in RUN: time loads on the next edge, state goes to SYNC, and set_ack pulses on the SYNC -> RUN transition cycle.
  - Valid request in HALT: time loads, set_ack pulses the next cycle, state stays HALT.
  - A set request in SYNC is held off until RUN.
- Simultaneous tick_1hz and accepted valid set in RUN: set wins, tick dropped, no pulses.
- hold:
  - RUN with hold = 1 -> HALT on the next edge; hold takes priority over a tick the same cycle.
  - HALT with hold = 0 -> SYNC, then RUN.
  - hold = 1 during SYNC -> HALT immediately; any pending set_ack for that set is issued on the same edge.
- Alarm:
  - On any cycle where time changed (tick update or valid load), if alarm_en = 1 and the new {hour,min,sec} == alarm_time, alarm_irq is set on the following edge.
  - alarm_clr clears alarm_irq; set beats clear when both occur the same cycle.
  - alarm_time is not range-checked; an invalid value never matches.
- rst mid-operation (any state) returns to the reset values above; an in-flight set is discarded with no ack.

Decomposition:
- Package `rtc_pkg`:
  - state enum RUN/SYNC/HALT;
  - BCD limit constants SEC_MAX = 8'h59, MIN_MAX = 8'h59, HOUR_MAX = 8'h23;
  - packed time struct {hour,min,sec};
  - a BCD-validity function.
- One sub-module `rtc_bcd_wrap`: a two-digit BCD counter with inputs inc, load, load_val and a LIMIT parameter; outputs value and wrap (carry). It is instantiated three times and chained.

Test Plan:
1. Reset released -> div_rst high exactly 4 cycles, then 0; time reads 00:00:00, all pulses 0.
2. Load 23:59:58, wait for ack, apply 2 ticks -> sec 0x59, then 00:00:00 with sec_pulse, min_pulse, hour_pulse and day_pulse coincident, 1 cycle after the second tick.
3. set_req with set_min = 0x60 -> set_ack and set_err pulse one cycle later, time unchanged, div_rst stays 0. Hold set_req high 10 cycles -> no second ack until set_req drops and reasserts.
4. Tick and valid set (12:34:56) in the same cycle -> time = 12:34:56, no sec_pulse, div_rst high 4 cycles, then set_ack.
5. hold = 1 with 5 ticks -> time frozen, div_rst high. Set 01:02:03 during HALT -> ack next cycle. Release hold -> SYNC 4 cycles, then the next tick gives 01:02:04.
6. alarm_time = 00:00:05, alarm_en = 1, start at 00:00:03, 2 ticks -> alarm_irq high after the second. alarm_clr plus a coincident new match -> alarm_irq stays 1.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared types and helpers for the RTC timekeeping controller.
package rtc_pkg;

  // Controller modes: counting, divider resync, and frozen.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SYNC = 2'd1,
    HALT = 2'd2
  } rtc_state_e;

  // Highest legal BCD value of each time field.
  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  // Packed time of day, hour in the top byte so it lines up with alarm_time.
  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } rtc_time_t;

  // Both digits must be decimal and the value must not exceed the field limit.
  // With two valid digits, BCD ordering equals binary ordering, so a plain
  // compare against the limit is enough.
  function automatic logic bcd_valid(input logic [7:0] val, input logic [7:0] limit);
    return (val[3:0] <= 4'd9) && (val[7:4] <= 4'd9) && (val <= limit);
  endfunction

endpackage

// File: rtl/rtc_bcd_wrap.sv
// Two-digit BCD counter that wraps to 00 after LIMIT and reports the carry.
module rtc_bcd_wrap #(
  parameter logic [7:0] LIMIT = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       wrap
);

  logic [7:0] value_q, value_d;
  logic       at_limit;

  assign at_limit = (value_q == LIMIT);
  // A load always wins, so a carry is only reported for a real increment.
  assign wrap     = inc && !load && at_limit;
  assign value    = value_q;

  // Next value: load, or BCD increment with units->tens carry and wrap at LIMIT.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (inc) begin
      if (at_limit) begin
        value_d = 8'h00;
      end else if (value_q[3:0] == 4'd9) begin
        value_d = {value_q[7:4] + 4'd1, 4'd0};
      end else begin
        value_d = {value_q[7:4], value_q[3:0] + 4'd1};
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) value_q <= 8'h00;
    else     value_q <= value_d;
  end

endmodule

// File: rtl/rtc_time_ctrl.sv
// 24 h BCD timekeeping controller fed by the 1 Hz divider. Sequences the
// divider reset so the sub-second phase restarts after reset, every time set
// and every resume from hold; provides a set handshake and a sticky alarm.
module rtc_time_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned DIV_RST_CYCLES   = 4,
  parameter bit          ALARM_EN_DEFAULT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  output logic        div_rst,
  input  logic        hold,
  input  logic        set_req,
  input  logic [7:0]  set_hour,
  input  logic [7:0]  set_min,
  input  logic [7:0]  set_sec,
  output logic        set_ack,
  output logic        set_err,
  output logic [7:0]  hour,
  output logic [7:0]  min,
  output logic [7:0]  sec,
  output logic        sec_pulse,
  output logic        min_pulse,
  output logic        hour_pulse,
  output logic        day_pulse,
  input  logic        alarm_en,
  input  logic [23:0] alarm_time,
  input  logic        alarm_clr,
  output logic        alarm_irq
);

  localparam logic [7:0] DIV_LOAD = DIV_RST_CYCLES[7:0];

  rtc_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       armed_q, armed_d;
  logic       ack_pend_q, ack_pend_d;
  logic       set_ack_q, set_ack_d;
  logic       set_err_q, set_err_d;
  logic       div_rst_q, div_rst_d;
  logic       sec_pulse_q, sec_pulse_d;
  logic       min_pulse_q, min_pulse_d;
  logic       hour_pulse_q, hour_pulse_d;
  logic       day_pulse_q, day_pulse_d;
  logic       chg_q, chg_d;
  logic       alarm_armed_q, alarm_armed_d;
  logic       alarm_irq_q, alarm_irq_d;

  logic       set_fire, set_ok, set_bad, tick_adv;
  logic       sec_wrap, min_wrap, hour_wrap;
  logic [7:0] sec_val, min_val, hour_val;
  rtc_time_t  cur;

  // Qualify the host request and the incoming tick for this cycle.
  always_comb begin
    set_fire = set_req && armed_q && (state_q != SYNC);
    set_ok   = set_fire && bcd_valid(set_hour, HOUR_MAX)
                        && bcd_valid(set_min, MIN_MAX)
                        && bcd_valid(set_sec, SEC_MAX);
    set_bad  = set_fire && !set_ok;
    // hold and an accepted load both swallow the tick.
    tick_adv = tick_1hz && (state_q == RUN) && !hold && !set_ok;
  end

  // Seconds -> minutes -> hours carry chain.
  rtc_bcd_wrap #(.LIMIT(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .inc(tick_adv), .load(set_ok), .load_val(set_sec),
    .value(sec_val), .wrap(sec_wrap)
  );

  rtc_bcd_wrap #(.LIMIT(MIN_MAX)) u_min (
    .clk(clk), .rst(rst), .inc(sec_wrap), .load(set_ok), .load_val(set_min),
    .value(min_val), .wrap(min_wrap)
  );

  rtc_bcd_wrap #(.LIMIT(HOUR_MAX)) u_hour (
    .clk(clk), .rst(rst), .inc(min_wrap), .load(set_ok), .load_val(set_hour),
    .value(hour_val), .wrap(hour_wrap)
  );

  assign cur  = '{hour: hour_val, min: min_val, sec: sec_val};
  assign hour = hour_val;
  assign min  = min_val;
  assign sec  = sec_val;

  // Mode sequencing, set handshake and the divider reset request.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_pend_d = ack_pend_q;
    set_ack_d  = set_bad;
    set_err_d  = set_bad;
    unique case (state_q)
      RUN: begin
        if (hold) begin
          // A load taken together with hold skips the resync it would abort.
          state_d = HALT;
          if (set_ok) set_ack_d = 1'b1;
        end else if (set_ok) begin
          state_d    = SYNC;
          cnt_d      = DIV_LOAD;
          ack_pend_d = 1'b1;
        end
      end
      SYNC: begin
        if (hold) begin
          state_d    = HALT;
          set_ack_d  = ack_pend_q;
          ack_pend_d = 1'b0;
        end else if (cnt_q <= 8'd1) begin
          state_d    = RUN;
          set_ack_d  = ack_pend_q;
          ack_pend_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HALT: begin
        if (set_ok) set_ack_d = 1'b1;
        if (!hold) begin
          state_d = SYNC;
          cnt_d   = DIV_LOAD;
        end
      end
      default: begin
        state_d = SYNC;
        cnt_d   = DIV_LOAD;
      end
    endcase
    div_rst_d = (state_d != RUN);
    // One accept per assertion: re-arm only once set_req has been seen low.
    if (set_fire)      armed_d = 1'b0;
    else if (!set_req) armed_d = 1'b1;
    else               armed_d = armed_q;
  end

  // Time-change pulses and the alarm; the match is evaluated on the new time
  // one cycle after it is registered.
  always_comb begin
    sec_pulse_d   = tick_adv;
    min_pulse_d   = sec_wrap;
    hour_pulse_d  = min_wrap;
    day_pulse_d   = hour_wrap;
    chg_d         = tick_adv || set_ok;
    alarm_armed_d = alarm_en;
    alarm_irq_d   = (chg_q && alarm_armed_q && (cur == alarm_time))
                 || (alarm_irq_q && !alarm_clr);
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SYNC;
      cnt_q         <= DIV_LOAD;
      armed_q       <= 1'b1;
      ack_pend_q    <= 1'b0;
      set_ack_q     <= 1'b0;
      set_err_q     <= 1'b0;
      div_rst_q     <= 1'b1;
      sec_pulse_q   <= 1'b0;
      min_pulse_q   <= 1'b0;
      hour_pulse_q  <= 1'b0;
      day_pulse_q   <= 1'b0;
      chg_q         <= 1'b0;
      alarm_armed_q <= ALARM_EN_DEFAULT;
      alarm_irq_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      ack_pend_q    <= ack_pend_d;
      set_ack_q     <= set_ack_d;
      set_err_q     <= set_err_d;
      div_rst_q     <= div_rst_d;
      sec_pulse_q   <= sec_pulse_d;
      min_pulse_q   <= min_pulse_d;
      hour_pulse_q  <= hour_pulse_d;
      day_pulse_q   <= day_pulse_d;
      chg_q         <= chg_d;
      alarm_armed_q <= alarm_armed_d;
      alarm_irq_q   <= alarm_irq_d;
    end
  end

  assign div_rst    = div_rst_q;
  assign set_ack    = set_ack_q;
  assign set_err    = set_err_q;
  assign sec_pulse  = sec_pulse_q;
  assign min_pulse  = min_pulse_q;
  assign hour_pulse = hour_pulse_q;
  assign day_pulse  = day_pulse_q;
  assign alarm_irq  = alarm_irq_q;

endmodule

// File: tb/tb_rtc_time_ctrl.sv
// Bench for rtc_time_ctrl: directed sequences, a set-validity table and a
// randomized run against a seconds-of-day reference model.
module tb_rtc_time_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_1hz = 1'b0, hold = 1'b0, set_req = 1'b0;
  logic [7:0]  set_hour = 8'h00, set_min = 8'h00, set_sec = 8'h00;
  logic        alarm_en = 1'b0, alarm_clr = 1'b0;
  logic [23:0] alarm_time = 24'h0;
  logic        div_rst, set_ack, set_err, sec_pulse, min_pulse, hour_pulse, day_pulse, alarm_irq;
  logic [7:0]  hour, min, sec;

  always #5 clk = ~clk;

  rtc_time_ctrl #(.DIV_RST_CYCLES(DIV), .ALARM_EN_DEFAULT(1'b0)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .div_rst(div_rst), .hold(hold),
    .set_req(set_req), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .set_ack(set_ack), .set_err(set_err), .hour(hour), .min(min), .sec(sec),
    .sec_pulse(sec_pulse), .min_pulse(min_pulse), .hour_pulse(hour_pulse),
    .day_pulse(day_pulse), .alarm_en(alarm_en), .alarm_time(alarm_time),
    .alarm_clr(alarm_clr), .alarm_irq(alarm_irq)
  );

  int tests = 0, fails = 0;

  // Reference model: time kept as seconds since midnight.
  int m_secs, m_mode, m_left; // mode 0 = run, 1 = sync, 2 = halt
  bit m_armed, m_pend, m_chg, m_en, m_irq;
  bit e_ack, e_err, e_sp, e_mp, e_hp, e_dp;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit field_ok(input logic [7:0] b, input int maxv);
    return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (from_bcd(b) <= maxv);
  endfunction

  function automatic logic [23:0] secs_bcd(input int s);
    return {to_bcd(s / 3600), to_bcd((s / 60) % 60), to_bcd(s % 60)};
  endfunction

  task automatic model_reset();
    m_secs = 0; m_mode = 1; m_left = DIV;
    m_armed = 1; m_pend = 0; m_chg = 0; m_en = 0; m_irq = 0;
    e_ack = 0; e_err = 0; e_sp = 0; e_mp = 0; e_hp = 0; e_dp = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit fire, ok, tk;
    int old;
    if (rst) begin
      model_reset();
    end else begin
      e_ack = 0; e_err = 0; e_sp = 0; e_mp = 0; e_hp = 0; e_dp = 0;
      m_irq = (m_chg && m_en && (secs_bcd(m_secs) == alarm_time)) || (m_irq && !alarm_clr);
      fire = set_req && m_armed && (m_mode != 1);
      ok = fire && field_ok(set_hour, 23) && field_ok(set_min, 59) && field_ok(set_sec, 59);
      if (fire && !ok) begin e_ack = 1; e_err = 1; end
      tk = tick_1hz && (m_mode == 0) && !hold && !ok;
      m_chg = ok || tk;
      m_en = alarm_en;
      if (ok) m_secs = from_bcd(set_hour) * 3600 + from_bcd(set_min) * 60 + from_bcd(set_sec);
      if (tk) begin
        old = m_secs;
        m_secs = (old + 1) % 86400;
        e_sp = 1; e_mp = (old % 60 == 59); e_hp = (old % 3600 == 3599); e_dp = (old == 86399);
      end
      case (m_mode)
        0: if (hold) begin m_mode = 2; if (ok) e_ack = 1; end
           else if (ok) begin m_mode = 1; m_left = DIV; m_pend = 1; end
        1: if (hold || m_left == 1) begin
             m_mode = hold ? 2 : 0;
             if (m_pend) e_ack = 1;
             m_pend = 0;
           end else m_left = m_left - 1;
        default: begin
          if (ok) e_ack = 1;
          if (!hold) begin m_mode = 1; m_left = DIV; end
        end
      endcase
      if (fire) m_armed = 0;
      else if (!set_req) m_armed = 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("model", {hour, min, sec, sec_pulse, min_pulse, hour_pulse, day_pulse,
                  set_ack, set_err, div_rst, alarm_irq},
                 {secs_bcd(m_secs), e_sp, e_mp, e_hp, e_dp, e_ack, e_err,
                  (m_mode != 0), m_irq});
  endtask

  // One clock: model advance, then compare on the falling edge.
  task automatic step();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Issue one set request and wait (bounded) for its acknowledge.
  task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                        output int lat);
    set_hour = h; set_min = m; set_sec = s; set_req = 1'b1;
    step();
    set_req = 1'b0;
    lat = 1;
    while (set_ack !== 1'b1 && lat < 30) begin step(); lat++; end
  endtask

  // Count cycles div_rst stays high from now (bounded).
  task automatic count_sync(output int n);
    n = 0;
    while (div_rst === 1'b1 && n < 30) begin n++; step(); end
  endtask

  typedef struct {
    logic [7:0]  h, m, s;
    logic        err;
    logic [23:0] t;
  } set_vec_t;

  set_vec_t tbl[8];

  initial begin
    int lat, n, nack;

    tbl[0] = '{8'h23, 8'h59, 8'h59, 1'b0, 24'h235959};
    tbl[1] = '{8'h24, 8'h00, 8'h00, 1'b1, 24'h235959};
    tbl[2] = '{8'h00, 8'h60, 8'h00, 1'b1, 24'h235959};
    tbl[3] = '{8'h00, 8'h00, 8'h5A, 1'b1, 24'h235959};
    tbl[4] = '{8'h1A, 8'h00, 8'h00, 1'b1, 24'h235959};
    tbl[5] = '{8'h00, 8'h00, 8'h00, 1'b0, 24'h000000};
    tbl[6] = '{8'h19, 8'h09, 8'h59, 1'b0, 24'h190959};
    tbl[7] = '{8'h09, 8'h5F, 8'h00, 1'b1, 24'h190959};

    model_reset();
    @(negedge clk);
    step(); step();

    // 1: reset release, divider held exactly DIV cycles
    rst = 1'b0;
    count_sync(n);
    chk("t1_div_rst_cycles", n, DIV);
    chk("t1_time", {hour, min, sec}, 24'h000000);
    chk("t1_pulses", {sec_pulse, min_pulse, hour_pulse, day_pulse}, 4'h0);

    // 2: midnight rollover
    do_set(8'h23, 8'h59, 8'h58, lat);
    chk("t2_set_latency", lat, DIV + 1);
    chk("t2_loaded", {hour, min, sec}, 24'h235958);
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
    chk("t2_sec59", {sec, 7'd0, sec_pulse}, {8'h59, 8'h01});
    step();
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
    chk("t2_midnight", {hour, min, sec}, 24'h000000);
    chk("t2_all_pulses", {sec_pulse, min_pulse, hour_pulse, day_pulse}, 4'hF);

    // 3: rejected set, one ack per assertion
    set_hour = 8'h00; set_min = 8'h60; set_sec = 8'h00; set_req = 1'b1;
    step();
    chk("t3_ack_err", {set_ack, set_err, div_rst}, 3'b110);
    chk("t3_time", {hour, min, sec}, 24'h000000);
    nack = 0;
    for (int i = 0; i < 10; i++) begin step(); if (set_ack) nack++; end
    chk("t3_no_reack", nack, 0);
    set_req = 1'b0; step();
    set_req = 1'b1; step();
    chk("t3_reack", {set_ack, set_err}, 2'b11);
    set_req = 1'b0; step();

    // 4: tick coincident with a valid set
    tick_1hz = 1'b1; set_hour = 8'h12; set_min = 8'h34; set_sec = 8'h56; set_req = 1'b1;
    step();
    tick_1hz = 1'b0; set_req = 1'b0;
    chk("t4_time", {hour, min, sec}, 24'h123456);
    chk("t4_no_pulse", sec_pulse, 1'b0);
    count_sync(n);
    chk("t4_sync_cycles", n, DIV);
    chk("t4_ack_on_run", set_ack, 1'b1);

    // 5: hold freezes time, set in halt, resume resyncs
    hold = 1'b1; step();
    chk("t5_halt", div_rst, 1'b1);
    for (int i = 0; i < 5; i++) begin tick_1hz = 1'b1; step(); tick_1hz = 1'b0; step(); end
    chk("t5_frozen", {hour, min, sec}, 24'h123456);
    do_set(8'h01, 8'h02, 8'h03, lat);
    chk("t5_halt_ack_latency", lat, 1);
    chk("t5_loaded", {hour, min, sec}, 24'h010203);
    hold = 1'b0; step();
    count_sync(n);
    chk("t5_resume_sync", n, DIV);
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
    chk("t5_after_tick", {hour, min, sec}, 24'h010204);

    // Set validity table, applied in halt so each ack follows immediately
    hold = 1'b1; step();
    foreach (tbl[i]) begin
      set_hour = tbl[i].h; set_min = tbl[i].m; set_sec = tbl[i].s; set_req = 1'b1;
      step();
      chk($sformatf("tbl%0d_ack_err", i), {set_ack, set_err}, {1'b1, tbl[i].err});
      chk($sformatf("tbl%0d_time", i), {hour, min, sec}, tbl[i].t);
      set_req = 1'b0; step();
    end
    hold = 1'b0; step();
    count_sync(n);

    // 6: alarm match, then clear racing a new match
    alarm_time = 24'h000005; alarm_en = 1'b1;
    do_set(8'h00, 8'h00, 8'h03, lat);
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
    chk("t6_match_time", {hour, min, sec}, 24'h000005);
    chk("t6_irq_not_yet", alarm_irq, 1'b0);
    step();
    chk("t6_irq_set", alarm_irq, 1'b1);
    hold = 1'b1; step();
    do_set(8'h00, 8'h00, 8'h05, lat);
    alarm_clr = 1'b1; step();
    chk("t6_set_beats_clr", alarm_irq, 1'b1);
    step();
    chk("t6_cleared", alarm_irq, 1'b0);
    alarm_clr = 1'b0; hold = 1'b0; step();
    count_sync(n);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      tick_1hz = ($urandom_range(3) == 0);
      if ($urandom_range(39) == 0) hold = ~hold;
      set_req = set_req ? ($urandom_range(2) != 0) : ($urandom_range(15) == 0);
      if (set_req && $urandom_range(1) == 0) begin
        case ($urandom_range(3))
          0: begin set_hour = 8'($urandom); set_min = 8'($urandom); set_sec = 8'($urandom); end
          1: begin set_hour = 8'h23; set_min = 8'h59; set_sec = to_bcd(50 + $urandom_range(9)); end
          2: begin set_hour = to_bcd($urandom_range(23)); set_min = 8'h59; set_sec = to_bcd(55 + $urandom_range(4)); end
          default: begin
            set_hour = to_bcd($urandom_range(23)); set_min = to_bcd($urandom_range(59));
            set_sec = to_bcd($urandom_range(59));
          end
        endcase
      end
      alarm_en = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0)
        alarm_time = ($urandom_range(1) == 0) ? 24'($urandom)
                                              : secs_bcd((m_secs + 1 + $urandom_range(2)) % 86400);
      alarm_clr = ($urandom_range(7) == 0);
      rst = ($urandom_range(499) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
